// File: rtl/uart_rx_line_buf.sv
// Receive-side line buffer: FIFO of bytes from uart_rx with newline (0x0A) line tracking.
// Optional UART_LINE_BUF_CR_STRIP_EN: discard 0x0D bytes at the write side.
module uart_rx_line_buf #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int LINE_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_end,
    input  logic [7:0]            rx_data,
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  line_ready,
    output logic [ADDR_W:0]       lines_pending,
    output logic [LINE_CNT_W-1:0] lines_total,
    output logic                  ovf,
    input  logic                  clr_ovf
);

    localparam logic [ADDR_W:0]       PTR_ONE = (ADDR_W+1)'(1);
    localparam logic [LINE_CNT_W-1:0] TOT_ONE = LINE_CNT_W'(1);

    logic [7:0]            mem_q [DEPTH];
    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       lines_pending_q, lines_pending_d;
    logic [LINE_CNT_W-1:0] lines_total_q, lines_total_d;
    logic                  ovf_q, ovf_d;

    logic empty, full_w, cr_byte, rx_ok, wr_fire, rd_fire, drop;
    logic wr_nl, rd_nl;
    logic [7:0] head;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_w = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign head   = mem_q[rd_ptr_q[ADDR_W-1:0]];

`ifdef UART_LINE_BUF_CR_STRIP_EN
    assign cr_byte = (rx_data == 8'h0D);
`else
    assign cr_byte = 1'b0;
`endif

    // When full, rd_valid is necessarily 1, so rd_en alone means a pop frees a slot.
    assign rx_ok   = rx_end & ~cr_byte;
    assign rd_fire = rd_en & ~empty;
    assign wr_fire = rx_ok & (~full_w | rd_en);
    assign drop    = rx_ok & full_w & ~rd_en;
    assign wr_nl   = wr_fire & (rx_data == 8'h0A);
    assign rd_nl   = rd_fire & (head == 8'h0A);

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        lines_pending_d = lines_pending_q;
        lines_total_d   = lines_total_q;
        ovf_d           = ovf_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_nl, rd_nl})
            2'b10:   lines_pending_d = lines_pending_q + PTR_ONE;
            2'b01:   lines_pending_d = lines_pending_q - PTR_ONE;
            default: lines_pending_d = lines_pending_q;
        endcase
        if (wr_nl) lines_total_d = lines_total_q + TOT_ONE;
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            lines_pending_q <= '0;
            lines_total_q   <= '0;
            ovf_q           <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            lines_pending_q <= lines_pending_d;
            lines_total_q   <= lines_total_d;
            ovf_q           <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_fire) mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_data;
    end

    assign rd_valid      = ~empty;
    assign rd_data       = empty ? 8'h00 : head;
    assign full          = full_w;
    assign line_ready    = (lines_pending_q != '0);
    assign lines_pending = lines_pending_q;
    assign lines_total   = lines_total_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_uart_rx_line_buf.sv
// Directed self-checking bench for uart_rx_line_buf (default DEPTH=16).
module tb_uart_rx_line_buf;

    logic       clk = 1'b0;
    logic       reset, rx_end, rd_en, clr_ovf;
    logic [7:0] rx_data;
    logic [7:0] rd_data;
    logic       rd_valid, full, line_ready, ovf;
    logic [4:0] lines_pending;
    logic [7:0] lines_total;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_rx_line_buf #(.DEPTH(16), .ADDR_W(4), .LINE_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .line_ready(line_ready), .lines_pending(lines_pending),
        .lines_total(lines_total), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    // Inputs change 1ns after the rising edge; outputs are checked in the same window.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; rx_end = 0; rd_en = 0; clr_ovf = 0; rx_data = 8'h00;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_end = 1; rx_data = b; tick(); rx_end = 0; rx_data = 8'h00;
    endtask

    task automatic pop();
        rd_en = 1; tick(); rd_en = 0;
    endtask

    task automatic test_reset();
        idle(); reset = 1; rx_end = 1; rx_data = 8'h41; tick(); idle();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (line_ready !== 1'b0) begin n_err++; $display("FAIL reset_line_ready got %b exp 0", line_ready); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        n_cmp++; if (lines_pending !== 5'd0) begin n_err++; $display("FAIL reset_pending got %0d exp 0", lines_pending); end
        n_cmp++; if (lines_total !== 8'd0) begin n_err++; $display("FAIL reset_total got %0d exp 0", lines_total); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_line();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h48; exp_b[1] = 8'h69; exp_b[2] = 8'h0A;
        do_reset();
        push(8'h48);
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL line_first_valid got %b exp 1", rd_valid); end
        n_cmp++; if (rd_data !== 8'h48) begin n_err++; $display("FAIL line_first_data got %h exp 48", rd_data); end
        tick(); push(8'h69); tick(); push(8'h0A); tick();
        n_cmp++; if (lines_pending !== 5'd1) begin n_err++; $display("FAIL line_pending got %0d exp 1", lines_pending); end
        n_cmp++; if (line_ready !== 1'b1) begin n_err++; $display("FAIL line_ready got %b exp 1", line_ready); end
        n_cmp++; if (lines_total !== 8'd1) begin n_err++; $display("FAIL line_total got %0d exp 1", lines_total); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rd_data !== exp_b[i]) begin n_err++; $display("FAIL line_pop%0d got %h exp %h", i, rd_data, exp_b[i]); end
            pop();
        end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL line_drained_valid got %b exp 0", rd_valid); end
        n_cmp++; if (line_ready !== 1'b0) begin n_err++; $display("FAIL line_drained_ready got %b exp 0", line_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %b exp 1", full); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_before got %b exp 0", ovf); end
        push(8'h55);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b exp 1", ovf); end
        n_cmp++; if (lines_total !== 8'd1) begin n_err++; $display("FAIL ovf_total got %0d exp 1", lines_total); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rd_data !== 8'(i)) begin n_err++; $display("FAIL ovf_pop%0d got %h exp %h", i, rd_data, 8'(i)); end
            pop();
        end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_no_55 got %b exp 0", rd_valid); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
        clr_ovf = 1; tick(); clr_ovf = 0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", ovf); end
        for (int i = 0; i < 16; i++) push(8'h30);
        rx_end = 1; rx_data = 8'h31; clr_ovf = 1; tick(); idle();
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_drop_beats_clr got %b exp 1", ovf); end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        n_cmp++; if (lines_pending !== 5'd0) begin n_err++; $display("FAIL frw_pending0 got %0d exp 0", lines_pending); end
        rx_end = 1; rx_data = 8'h0A; rd_en = 1; tick(); idle();
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL frw_full got %b exp 1", full); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL frw_ovf got %b exp 0", ovf); end
        n_cmp++; if (lines_pending !== 5'd1) begin n_err++; $display("FAIL frw_pending got %0d exp 1", lines_pending); end
        for (int i = 1; i < 16; i++) begin
            n_cmp++; if (rd_data !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL frw_pop%0d got %h exp %h", i, rd_data, 8'h20 + 8'(i)); end
            pop();
        end
        n_cmp++; if (rd_data !== 8'h0A) begin n_err++; $display("FAIL frw_last got %h exp 0a", rd_data); end
        pop();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL frw_empty got %b exp 0", rd_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rd_en = 1; rx_end = 1; rx_data = 8'h33; tick(); idle();
        n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL b2b_empty_rd got %b exp 1", rd_valid); end
        n_cmp++; if (rd_data !== 8'h33) begin n_err++; $display("FAIL b2b_empty_data got %h exp 33", rd_data); end
        pop();
        push(8'h0A);
        n_cmp++; if (lines_total !== 8'd1) begin n_err++; $display("FAIL b2b_total1 got %0d exp 1", lines_total); end
        rd_en = 1; rx_end = 1; rx_data = 8'h0A; tick(); idle();
        n_cmp++; if (lines_pending !== 5'd1) begin n_err++; $display("FAIL b2b_pending got %0d exp 1", lines_pending); end
        n_cmp++; if (lines_total !== 8'd2) begin n_err++; $display("FAIL b2b_total2 got %0d exp 2", lines_total); end
        n_cmp++; if (rd_data !== 8'h0A) begin n_err++; $display("FAIL b2b_head got %h exp 0a", rd_data); end
        pop();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_one_left got %b exp 0", rd_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h0A);
        reset = 1; rx_end = 1; rx_data = 8'h77; tick(); idle();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %b exp 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rmid_data got %h exp 00", rd_data); end
        n_cmp++; if (lines_pending !== 5'd0) begin n_err++; $display("FAIL rmid_pending got %0d exp 0", lines_pending); end
        n_cmp++; if (lines_total !== 8'd0) begin n_err++; $display("FAIL rmid_total got %0d exp 0", lines_total); end
        tick();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rmid_absent got %b exp 0", rd_valid); end
    endtask

    task automatic test_cr();
        logic [7:0] got [$];
        logic [7:0] exp_b [$];
        logic       exp_ovf;
`ifdef UART_LINE_BUF_CR_STRIP_EN
        exp_b = '{8'h41, 8'h0A};
        exp_ovf = 1'b0;
`else
        exp_b = '{8'h41, 8'h0D, 8'h0A};
        exp_ovf = 1'b1;
`endif
        do_reset();
        push(8'h41); push(8'h0D); push(8'h0A);
        for (int i = 0; i < 20 && rd_valid; i++) begin
            got.push_back(rd_data);
            pop();
        end
        n_cmp++; if (got.size() !== exp_b.size()) begin n_err++; $display("FAIL cr_count got %0d exp %0d", got.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_b[i]) begin n_err++; $display("FAIL cr_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
        for (int i = 0; i < 16; i++) push(8'h41);
        push(8'h0D);
        n_cmp++; if (ovf !== exp_ovf) begin n_err++; $display("FAIL cr_full_ovf got %b exp %b", ovf, exp_ovf); end
    endtask

    initial begin
        idle();
        tick();
        test_reset();
        test_line();
        test_overflow();
        test_full_rw();
        test_back_to_back();
        test_reset_mid();
        test_cr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
